// File: rtl/rom_stream_reader_pkg.sv
// ---------------------------------------------------------------------------
// rom_stream_reader_pkg
// Purpose : shared definitions for the ROM stream reader slice. Holds the
//           default memory geometry, the read-buffer depth, and the burst
//           sequencer state encoding.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package rom_stream_reader_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    // Two entries cover the one-cycle memory latency plus one stalled byte,
    // which is exactly what a full-rate stream needs.
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage : rom_stream_reader_pkg

// File: rtl/rom_stream_reader_fifo2.sv
// ---------------------------------------------------------------------------
// rom_stream_fifo2
// Purpose : two-entry FIFO that catches bytes returning from the memory and
//           holds them until the stream consumer takes them.
// Ports   : Clock      - clock, all state on posedge
//           Reset_n    - asynchronous active-low reset
//           push       - write push_data at the next edge
//           push_data  - byte to store
//           pop        - drop the head entry at the next edge
//           head_data  - oldest stored byte (0 after reset)
//           not_empty  - at least one byte stored
//           count      - number of stored bytes, 0..2
// ---------------------------------------------------------------------------
module rom_stream_fifo2
    import rom_stream_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              not_empty,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] slot [FIFO_DEPTH];
    logic              rd_ptr;
    logic              wr_ptr;
    logic              pop_ok;

    assign not_empty = (count != 2'd0);
    assign head_data = slot[rd_ptr];

    // A pop on an empty FIFO is ignored so the pointers can never slip.
    assign pop_ok = pop && not_empty;

    // Storage, pointers and occupancy. Storage is cleared on reset so the
    // stream data output reads 0 until the first byte lands.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= push_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // The issuing side only requests a read when a slot is guaranteed, so a
    // push into a full FIFO without a matching pop means the credit logic broke.
    overflow_check: assert property (
        @(posedge Clock) disable iff (!Reset_n)
        !(push && !pop_ok && (count == 2'(FIFO_DEPTH)))
    );

endmodule : rom_stream_fifo2

// File: rtl/rom_stream_reader.sv
// ---------------------------------------------------------------------------
// rom_stream_reader
// Purpose : read-side burst sequencer for the 16x8 clocked memory. On Start it
//           walks Length consecutive addresses from Start_Addr (wrapping),
//           hides the memory's one-cycle read latency and presents the bytes
//           as a valid/ready stream with backpressure. Never writes memory.
// Ports   : Clock        - clock, all state on posedge
//           Reset_n      - asynchronous active-low reset
//           Start        - begin a burst (only looked at while idle)
//           Start_Addr   - first address of the burst
//           Length       - bytes to read; 0 = empty burst, above depth clamps
//           Busy         - burst in progress
//           Done         - one-cycle pulse when a burst finishes
//           Mem_Address  - memory address, follows the address counter
//           Mem_WE       - memory write enable, tied low
//           Mem_Data_Out - memory read data, one cycle after the address
//           Out_Data     - stream data
//           Out_Valid    - stream valid
//           Out_Ready    - stream ready from the consumer
// ---------------------------------------------------------------------------
module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Start_Addr,
    input  logic [ADDR_W:0]   Length,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic              Mem_WE,
    input  logic [DATA_W-1:0] Mem_Data_Out,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready
);

    localparam logic [ADDR_W:0] DEPTH_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remain;
    logic [ADDR_W:0]   len_clamped;
    logic              inflight;
    logic              done_q;
    logic              issue;
    logic              last_pop;
    logic              pop;
    logic              start_go;
    logic              start_empty;
    logic [1:0]        fifo_count;
    logic [2:0]        occupancy;

    assign len_clamped = (Length > DEPTH_FULL) ? DEPTH_FULL : Length;
    assign start_go    = (state == ST_IDLE) && Start && (len_clamped != '0);
    assign start_empty = (state == ST_IDLE) && Start && (len_clamped == '0);

    assign pop = Out_Valid && Out_Ready;

    // Bytes already committed to the FIFO: stored ones plus the read in
    // flight, minus the one leaving this cycle. A new read may only issue
    // when it is certain to find a free slot.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    assign Busy        = (state != ST_IDLE);
    assign Done        = done_q;
    assign Mem_Address = addr;
    assign Mem_WE      = 1'b0;

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the per-cycle issue and end-of-burst decisions.
    // DRAIN ends only when the final byte is handed over: nothing in flight
    // and the FIFO holding just that one byte.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        last_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_go) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                issue = (remain != '0) && (occupancy < 3'(FIFO_DEPTH));
                if (issue && (remain == (ADDR_W+1)'(1))) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                last_pop = pop && !inflight && (fifo_count == 2'd1);
                if (last_pop) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address/remaining counters, the in-flight flag that marks the memory
    // output as worth capturing next edge, and the Done pulse. Clearing the
    // in-flight flag on reset is what discards a read caught mid-burst.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            addr     <= '0;
            remain   <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            inflight <= issue;
            done_q   <= start_empty || last_pop;
            if (start_go) begin
                addr   <= Start_Addr;
                remain <= len_clamped;
            end else if (issue) begin
                addr   <= addr + 1'b1;
                remain <= remain - 1'b1;
            end
        end
    end

    rom_stream_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .push      (inflight),
        .push_data (Mem_Data_Out),
        .pop       (pop),
        .head_data (Out_Data),
        .not_empty (Out_Valid),
        .count     (fifo_count)
    );

endmodule : rom_stream_reader

// File: tb/tb_rom_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_rom_stream_reader
// Purpose : directed self-checking bench for rom_stream_reader. Contains a
//           behavioural 16x8 clocked ROM (Memory[i] = 8'h11*i) wired to the
//           DUT's memory port.
// ---------------------------------------------------------------------------
module tb_rom_stream_reader;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] length;
    logic       busy;
    logic       done;
    logic [3:0] mem_address;
    logic       mem_we;
    logic [7:0] mem_data_out;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    logic [7:0] memory [16];
    logic [7:0] got [16];

    int         checks   = 0;
    int         failures = 0;

    int         idx;
    int         cyc;
    logic       prev_stall;
    logic       saw_done;
    logic       rdy;
    logic [7:0] prev_data;

    always #5 clock = ~clock;

    rom_stream_reader #(
        .ADDR_W (4),
        .DATA_W (8)
    ) dut (
        .Clock        (clock),
        .Reset_n      (reset_n),
        .Start        (start),
        .Start_Addr   (start_addr),
        .Length       (length),
        .Busy         (busy),
        .Done         (done),
        .Mem_Address  (mem_address),
        .Mem_WE       (mem_we),
        .Mem_Data_Out (mem_data_out),
        .Out_Data     (out_data),
        .Out_Valid    (out_valid),
        .Out_Ready    (out_ready)
    );

    // Clocked ROM: registered read, one cycle of latency.
    always @(posedge clock) begin
        mem_data_out <= memory[mem_address];
    end

    function automatic logic [7:0] rom_value(input int a);
        return 8'(8'h11 * (a % 16));
    endfunction

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_int(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge; the write enable must be
    // low in every cycle of every test.
    task automatic tick();
        @(posedge clock);
        #1;
        check_bit("mem_we", mem_we, 1'b0);
    endtask

    task automatic apply_stimulus(input logic s, input logic [3:0] sa, input logic [4:0] len,
                                  input logic ready);
        start      = s;
        start_addr = sa;
        length     = len;
        out_ready  = ready;
    endtask

    task automatic check_output(input string tag, input logic exp_valid, input logic [7:0] exp_data,
                                input logic exp_busy, input logic exp_done);
        check_bit({tag, ".valid"}, out_valid, exp_valid);
        if (exp_valid) begin
            check_byte({tag, ".data"}, out_data, exp_data);
        end
        check_bit({tag, ".busy"}, busy, exp_busy);
        check_bit({tag, ".done"}, done, exp_done);
    endtask

    // Full-rate burst with ready held high. Expected timing: two quiet
    // cycles after Start, n_exp consecutive bytes, Done, then idle.
    // junk_start raises Start during the busy cycles; it must be ignored.
    task automatic burst(input string tag, input logic [3:0] sa, input logic [4:0] len,
                         input int n_exp, input logic junk_start);
        apply_stimulus(1'b1, sa, len, 1'b1);
        tick();
        if (n_exp == 0) begin
            apply_stimulus(1'b0, sa, len, 1'b1);
            check_output({tag, ".c0"}, 1'b0, 8'h00, 1'b0, 1'b1);
            tick();
            check_output({tag, ".c1"}, 1'b0, 8'h00, 1'b0, 1'b0);
        end else begin
            apply_stimulus(junk_start, 4'hA, 5'd5, 1'b1);
            check_output({tag, ".c0"}, 1'b0, 8'h00, 1'b1, 1'b0);
            tick();
            apply_stimulus(1'b0, sa, len, 1'b1);
            check_output({tag, ".c1"}, 1'b0, 8'h00, 1'b1, 1'b0);
            for (int i = 0; i < n_exp; i++) begin
                tick();
                check_output({tag, ".byte"}, 1'b1, rom_value(int'(sa) + i), 1'b1, 1'b0);
                got[i] = out_data;
            end
            tick();
            check_output({tag, ".done"}, 1'b0, 8'h00, 1'b0, 1'b1);
            tick();
            check_output({tag, ".idle"}, 1'b0, 8'h00, 1'b0, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            memory[i] = 8'(8'h11 * i);
        end
        reset_n = 1'b1;
        apply_stimulus(1'b0, 4'd0, 5'd0, 1'b0);
        #1 reset_n = 1'b0;
        #2;

        // Reset values.
        check_bit("reset.busy", busy, 1'b0);
        check_bit("reset.done", done, 1'b0);
        check_bit("reset.valid", out_valid, 1'b0);
        check_byte("reset.data", out_data, 8'h00);
        check_int("reset.mem_address", int'(mem_address), 0);
        check_bit("reset.mem_we", mem_we, 1'b0);
        #9 reset_n = 1'b1;
        tick();
        check_output("idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Test 1: basic burst 2..5.
        $display("[TB] test 1: Start_Addr=2 Length=4");
        burst("t1", 4'd2, 5'd4, 4, 1'b0);
        check_byte("t1.got0", got[0], 8'h22);
        check_byte("t1.got1", got[1], 8'h33);
        check_byte("t1.got2", got[2], 8'h44);
        check_byte("t1.got3", got[3], 8'h55);
        check_int("t1.mem_address", int'(mem_address), 6);

        // Test 2: wrap 15 -> 0.
        $display("[TB] test 2: Start_Addr=14 Length=4");
        burst("t2", 4'd14, 5'd4, 4, 1'b0);
        check_byte("t2.got0", got[0], 8'hEE);
        check_byte("t2.got1", got[1], 8'hFF);
        check_byte("t2.got2", got[2], 8'h00);
        check_byte("t2.got3", got[3], 8'h11);
        check_int("t2.mem_address", int'(mem_address), 2);

        // Test 3: full 16-byte burst with ready pattern 1,0,0,1.
        $display("[TB] test 3: Length=16 with backpressure");
        apply_stimulus(1'b1, 4'd0, 5'd16, 1'b1);
        tick();
        apply_stimulus(1'b0, 4'd0, 5'd16, 1'b1);
        idx        = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        saw_done   = 1'b0;
        while (!saw_done && cyc < 200) begin
            if (done === 1'b1) begin
                saw_done = 1'b1;
            end else begin
                if (prev_stall) begin
                    check_bit("t3.hold_valid", out_valid, 1'b1);
                    check_byte("t3.hold_data", out_data, prev_data);
                end
                rdy       = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                out_ready = rdy;
                if (out_valid && rdy) begin
                    check_byte("t3.data", out_data, rom_value(idx));
                    idx++;
                end
                prev_stall = out_valid && !rdy;
                prev_data  = out_data;
                tick();
                cyc++;
            end
        end
        check_bit("t3.done_seen", saw_done, 1'b1);
        check_int("t3.byte_count", idx, 16);
        out_ready = 1'b1;
        tick();
        check_output("t3.idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Test 4: empty burst, then an over-long burst that clamps to 16.
        $display("[TB] test 4: Length=0 and Length=20");
        burst("t4.empty", 4'd7, 5'd0, 0, 1'b0);
        burst("t4.clamp", 4'd9, 5'd20, 16, 1'b0);
        check_int("t4.mem_address", int'(mem_address), 9);

        // Test 5: reset after three bytes, then a fresh short burst.
        $display("[TB] test 5: reset mid-burst");
        apply_stimulus(1'b1, 4'd8, 5'd10, 1'b1);
        tick();
        apply_stimulus(1'b0, 4'd8, 5'd10, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("t5.byte", 1'b1, rom_value(8 + i), 1'b1, 1'b0);
        end
        reset_n = 1'b0;
        #1;
        check_bit("t5.rst.busy", busy, 1'b0);
        check_bit("t5.rst.done", done, 1'b0);
        check_bit("t5.rst.valid", out_valid, 1'b0);
        check_byte("t5.rst.data", out_data, 8'h00);
        check_int("t5.rst.mem_address", int'(mem_address), 0);
        #3 reset_n = 1'b1;
        tick();
        check_output("t5.quiet0", 1'b0, 8'h00, 1'b0, 1'b0);
        check_byte("t5.quiet0.data", out_data, 8'h00);
        tick();
        check_output("t5.quiet1", 1'b0, 8'h00, 1'b0, 1'b0);
        burst("t5.fresh", 4'd5, 5'd2, 2, 1'b0);
        check_byte("t5.got0", got[0], 8'h55);
        check_byte("t5.got1", got[1], 8'h66);
        check_int("t5.mem_address", int'(mem_address), 7);

        // Test 6: Start raised while busy must not disturb the burst.
        $display("[TB] test 6: Start while Busy");
        burst("t6", 4'd1, 5'd3, 3, 1'b1);
        check_byte("t6.got0", got[0], 8'h11);
        check_byte("t6.got1", got[1], 8'h22);
        check_byte("t6.got2", got[2], 8'h33);
        check_int("t6.mem_address", int'(mem_address), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rom_stream_reader
